// File: rtl/iob_axis2axi_in_sched.sv
// iob_axis2axi_in_sched: descriptor-queued scheduler that feeds one {addr, len} buffer at a time to a stream-to-AXI write datapath.
// Define IOB_AXIS2AXI_IN_SCHED_IRQ_EN to add a sticky done interrupt (irq_clr_i / irq_o).
module iob_axis2axi_in_sched #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int LEN_W      = 16,
  parameter int DESC_W     = 2
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  desc_valid_i,
  output logic                  desc_ready_o,
  input  logic [AXI_ADDR_W-1:0] desc_addr_i,
  input  logic [LEN_W-1:0]      desc_len_i,
  input  logic                  s_axis_valid_i,
  output logic                  s_axis_ready_o,
  input  logic [AXI_DATA_W-1:0] s_axis_data_i,
  output logic                  m_axis_valid_o,
  input  logic                  m_axis_ready_i,
  output logic [AXI_DATA_W-1:0] m_axis_data_o,
  output logic                  config_in_valid_o,
  output logic [AXI_ADDR_W-1:0] config_in_addr_o,
  input  logic                  config_in_ready_i,
  output logic                  done_o,
  output logic                  busy_o,
`ifdef IOB_AXIS2AXI_IN_SCHED_IRQ_EN
  input  logic                  irq_clr_i,
  output logic                  irq_o,
`endif
  output logic [DESC_W:0]       desc_level_o
);
  typedef enum logic [1:0] {IDLE, CONFIG, STREAM, DRAIN} state_t;
  state_t                state;
  logic [AXI_ADDR_W-1:0] q_addr [2**DESC_W];
  logic [LEN_W-1:0]      q_len  [2**DESC_W];
  logic [DESC_W-1:0]     wr_ptr, rd_ptr;
  logic [AXI_ADDR_W-1:0] act_addr;
  logic [LEN_W-1:0]      act_len, cnt;
  logic                  drain_wait;
  logic                  push, pop, hs, in_stream;
  assign in_stream         = state == STREAM;
  // level only reaches 2**DESC_W when full, so its top bit is the full flag
  assign desc_ready_o      = ~desc_level_o[DESC_W];
  assign push              = desc_valid_i & desc_ready_o;
  // holding off the pop while done_o is high guarantees the IDLE cycle between descriptors
  assign pop               = state == IDLE & |desc_level_o & ~done_o;
  assign hs                = in_stream & s_axis_valid_i & m_axis_ready_i;
  assign m_axis_valid_o    = in_stream & s_axis_valid_i;
  assign s_axis_ready_o    = in_stream & m_axis_ready_i;
  assign m_axis_data_o     = in_stream ? s_axis_data_i : '0;
  assign config_in_valid_o = state == CONFIG & config_in_ready_i;
  assign config_in_addr_o  = act_addr & ~AXI_ADDR_W'(3);
  assign busy_o            = state != IDLE;
  always_ff @(posedge clk_i)
    if (push) begin
      q_addr[wr_ptr] <= desc_addr_i;
      q_len[wr_ptr]  <= desc_len_i;
    end
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      desc_level_o <= '0;
    end else begin
      wr_ptr       <= wr_ptr + DESC_W'(push);
      rd_ptr       <= rd_ptr + DESC_W'(pop);
      desc_level_o <= desc_level_o + (DESC_W+1)'(push) - (DESC_W+1)'(pop);
    end
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) begin
      state      <= IDLE;
      act_addr   <= '0;
      act_len    <= '0;
      cnt        <= '0;
      drain_wait <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          act_addr <= q_addr[rd_ptr];
          act_len  <= q_len[rd_ptr];
          cnt      <= '0;
          if (q_len[rd_ptr] == '0) done_o <= 1'b1;
          else state <= CONFIG;
        end
        CONFIG: if (config_in_ready_i) state <= STREAM;
        STREAM: if (hs) begin
          cnt <= cnt + LEN_W'(1);
          if (cnt + LEN_W'(1) == act_len) begin
            state      <= DRAIN;
            drain_wait <= 1'b0;
          end
        end
        DRAIN: if (!drain_wait) drain_wait <= 1'b1;
          else if (config_in_ready_i) begin
            state  <= IDLE;
            done_o <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
`ifdef IOB_AXIS2AXI_IN_SCHED_IRQ_EN
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) irq_o <= 1'b0;
    else irq_o <= done_o | (irq_o & ~irq_clr_i);
`endif
endmodule

// File: tb/tb_iob_axis2axi_in_sched.sv
// tb_iob_axis2axi_in_sched: cycle table, directed corner sequences and a randomized run scored against a descriptor/word-order model.
module tb_iob_axis2axi_in_sched;
  logic        clk = 1'b0, arst_n = 1'b1;
  logic        desc_valid = 1'b0, desc_ready;
  logic [31:0] desc_addr = '0;
  logic [15:0] desc_len = '0;
  logic        s_valid = 1'b0, s_ready;
  logic [31:0] s_data = '0;
  logic        m_valid, m_ready = 1'b0;
  logic [31:0] m_data;
  logic        cfg_valid, cfg_ready = 1'b0;
  logic [31:0] cfg_addr;
  logic        done, busy;
  logic [2:0]  level;
`ifdef IOB_AXIS2AXI_IN_SCHED_IRQ_EN
  logic        irq_clr = 1'b0, irq;
`endif
  always #5 clk = ~clk;

  iob_axis2axi_in_sched dut (
    .clk_i(clk), .arst_n_i(arst_n),
    .desc_valid_i(desc_valid), .desc_ready_o(desc_ready), .desc_addr_i(desc_addr), .desc_len_i(desc_len),
    .s_axis_valid_i(s_valid), .s_axis_ready_o(s_ready), .s_axis_data_i(s_data),
    .m_axis_valid_o(m_valid), .m_axis_ready_i(m_ready), .m_axis_data_o(m_data),
    .config_in_valid_o(cfg_valid), .config_in_addr_o(cfg_addr), .config_in_ready_i(cfg_ready),
    .done_o(done), .busy_o(busy),
`ifdef IOB_AXIS2AXI_IN_SCHED_IRQ_EN
    .irq_clr_i(irq_clr), .irq_o(irq),
`endif
    .desc_level_o(level)
  );

  int n_chk = 0, n_pass = 0;
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction
  function automatic void fail(string name, logic [63:0] act);
    n_chk++;
    $display("FAIL %s: got %0h", name, act);
  endfunction

  // scoreboard: expected config addresses, expected words per descriptor (FIFO order), expected stream word sequence
  logic        mon_en = 1'b0, rec_en = 1'b0, src_auto = 1'b0, toggle = 1'b0, watch = 1'b0, saw_done = 1'b0, src_hs = 1'b0;
  logic [31:0] exp_cfg[$];
  int          exp_len[$];
  logic [31:0] exp_word = '0;
  int          words_cur = 0, dones = 0, cyc_n = 0, last_done = -100;
  always @(negedge clk) begin
    cyc_n++;
    src_hs = s_valid & s_ready;
    if (watch && done) saw_done = 1'b1;
    if (mon_en) begin
      if (rec_en && desc_valid && desc_ready) begin
        exp_len.push_back(int'(desc_len));
        if (desc_len != 16'd0) exp_cfg.push_back({desc_addr[31:2], 2'b00});
      end
      if (cfg_valid) begin
        if (exp_cfg.size() == 0) fail("cfg_unexpected", 64'(cfg_addr));
        else chk("cfg_addr", 64'(cfg_addr), 64'(exp_cfg.pop_front()));
        chk("done_to_cfg_gap_ge2", 64'(cyc_n - last_done >= 2), 64'd1);
      end
      if (m_valid && m_ready) begin
        chk("m_data_order", 64'(m_data), 64'(exp_word));
        exp_word = exp_word + 32'd1;
        words_cur++;
      end
      if (done) begin
        if (exp_len.size() == 0) fail("done_unexpected", 64'(dones));
        else chk("desc_words", 64'(words_cur), 64'(exp_len.pop_front()));
        words_cur = 0;
        dones++;
        last_done = cyc_n;
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
    if (src_auto && src_hs) s_data = s_data + 32'd1;
    if (toggle) m_ready = ~m_ready;
  endtask

  task automatic drain(int maxc);
    int n = 0;
    @(negedge clk); #1;
    while (exp_len.size() != 0 && n < maxc) begin
      cyc(); @(negedge clk); #1; n++;
    end
    if (exp_len.size() != 0) fail("drain_timeout_pending", 64'(exp_len.size()));
    chk("cfg_left", 64'(exp_cfg.size()), 64'd0);
  endtask

  task automatic check_reset(string t);
    chk({t, "_desc_ready"}, 64'(desc_ready), 64'd1);
    chk({t, "_level"}, 64'(level), 64'd0);
    chk({t, "_busy"}, 64'(busy), 64'd0);
    chk({t, "_done"}, 64'(done), 64'd0);
    chk({t, "_cfg_valid"}, 64'(cfg_valid), 64'd0);
    chk({t, "_cfg_addr"}, 64'(cfg_addr), 64'd0);
    chk({t, "_m_valid"}, 64'(m_valid), 64'd0);
    chk({t, "_s_ready"}, 64'(s_ready), 64'd0);
    chk({t, "_m_data"}, 64'(m_data), 64'd0);
`ifdef IOB_AXIS2AXI_IN_SCHED_IRQ_EN
    chk({t, "_irq"}, 64'(irq), 64'd0);
`endif
  endtask

  typedef struct {
    logic dv; logic [31:0] addr; logic [15:0] len; logic sv; logic [31:0] sd; logic mr, cr;
    logic e_dr, e_cv; logic [31:0] e_ca; logic e_mv; logic [31:0] e_md; logic e_sr, e_dn, e_bz; logic [2:0] e_lv;
  } vec_t;
  vec_t tbl[13];

  initial begin
    int n, d0;
    // single descriptor 0x1000/len 5, cycle by cycle; DRAIN ignores ready in its first cycle (row 8)
    tbl[0]  = '{1'b1, 32'h1000, 16'd5, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 3'd0};
    tbl[1]  = '{1'b0, 32'h0,    16'd0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 3'd1};
    tbl[2]  = '{1'b0, 32'h0,    16'd0, 1'b1, 32'hA0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1000, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 3'd0};
    for (int i = 3; i < 8; i++)
      tbl[i] = '{1'b0, 32'h0, 16'd0, 1'b1, 32'hA0 + 32'(i - 3), 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hA0 + 32'(i - 3), 1'b1, 1'b0, 1'b1, 3'd0};
    tbl[8]  = '{1'b0, 32'h0,    16'd0, 1'b1, 32'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 3'd0};
    tbl[9]  = '{1'b0, 32'h0,    16'd0, 1'b1, 32'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 3'd0};
    tbl[10] = '{1'b0, 32'h0,    16'd0, 1'b1, 32'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 3'd0};
    tbl[11] = '{1'b0, 32'h0,    16'd0, 1'b1, 32'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 3'd0};
    tbl[12] = '{1'b0, 32'h0,    16'd0, 1'b1, 32'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 3'd0};

    #2 arst_n = 1'b0;
    desc_valid = 1'b1; s_valid = 1'b1; m_ready = 1'b1; cfg_ready = 1'b1; s_data = 32'hDEAD;
    repeat (2) @(posedge clk);
    #1 check_reset("por");
    desc_valid = 1'b0; s_valid = 1'b0; m_ready = 1'b0; cfg_ready = 1'b0;
    @(negedge clk) arst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      cyc();
      desc_valid = tbl[i].dv; desc_addr = tbl[i].addr; desc_len = tbl[i].len;
      s_valid = tbl[i].sv; s_data = tbl[i].sd; m_ready = tbl[i].mr; cfg_ready = tbl[i].cr;
      @(negedge clk);
      chk($sformatf("t%0d_desc_ready", i), 64'(desc_ready), 64'(tbl[i].e_dr));
      chk($sformatf("t%0d_cfg_valid", i), 64'(cfg_valid), 64'(tbl[i].e_cv));
      if (tbl[i].e_cv) chk($sformatf("t%0d_cfg_addr", i), 64'(cfg_addr), 64'(tbl[i].e_ca));
      chk($sformatf("t%0d_m_valid", i), 64'(m_valid), 64'(tbl[i].e_mv));
      if (tbl[i].e_mv) chk($sformatf("t%0d_m_data", i), 64'(m_data), 64'(tbl[i].e_md));
      chk($sformatf("t%0d_s_ready", i), 64'(s_ready), 64'(tbl[i].e_sr));
      chk($sformatf("t%0d_done", i), 64'(done), 64'(tbl[i].e_dn));
      chk($sformatf("t%0d_busy", i), 64'(busy), 64'(tbl[i].e_bz));
      chk($sformatf("t%0d_level", i), 64'(level), 64'(tbl[i].e_lv));
    end

    // queue full: a blocker held in CONFIG, then 5 pushes; the 5th (0x400) must be refused at level 4
    mon_en = 1'b1; src_auto = 1'b1; exp_word = s_data; s_valid = 1'b1; m_ready = 1'b1; cfg_ready = 1'b0;
    exp_cfg.push_back(32'hF00); exp_len.push_back(1);
    for (int i = 0; i < 4; i++) begin exp_cfg.push_back(32'(i) * 32'h100); exp_len.push_back(2); end
    d0 = dones;
    for (int i = 0; i < 6; i++) begin
      cyc();
      desc_valid = 1'b1;
      desc_addr = (i == 0) ? 32'hF00 : 32'(i - 1) * 32'h100;
      desc_len = (i == 0) ? 16'd1 : 16'd2;
      @(negedge clk);
      if (i == 4) begin chk("full_ready_lvl3", 64'(desc_ready), 64'd1); chk("full_level3", 64'(level), 64'd3); end
      if (i == 5) begin chk("full_ready_lvl4", 64'(desc_ready), 64'd0); chk("full_level4", 64'(level), 64'd4); end
    end
    cyc(); desc_valid = 1'b0; cfg_ready = 1'b1;
    drain(300);
    chk("full_dones", 64'(dones - d0), 64'd5);
    chk("full_level_end", 64'(level), 64'd0);

    // zero length then len 2: the first completes with no config strobe
    d0 = dones;
    exp_len.push_back(0); exp_len.push_back(2); exp_cfg.push_back(32'h2004);
    cyc(); desc_valid = 1'b1; desc_addr = 32'h1000; desc_len = 16'd0;
    cyc(); desc_addr = 32'h2007; desc_len = 16'd2;
    cyc(); desc_valid = 1'b0;
    drain(100);
    chk("zero_dones", 64'(dones - d0), 64'd2);

    // backpressure: m_axis_ready_i toggles each cycle, len 4
    d0 = dones;
    exp_len.push_back(4); exp_cfg.push_back(32'h3000);
    toggle = 1'b1;
    cyc(); desc_valid = 1'b1; desc_addr = 32'h3000; desc_len = 16'd4;
    cyc(); desc_valid = 1'b0;
    drain(100);
    toggle = 1'b0; m_ready = 1'b1;
    chk("bp_dones", 64'(dones - d0), 64'd1);

    // randomized traffic scored against the model
    rec_en = 1'b1;
    for (int i = 0; i < 800; i++) begin
      cyc();
      desc_valid = (i < 600) && ($urandom_range(0, 3) == 0);
      desc_addr = $urandom;
      desc_len = 16'($urandom_range(0, 5));
      s_valid = $urandom_range(0, 3) != 0;
      m_ready = $urandom_range(0, 3) != 0;
      cfg_ready = $urandom_range(0, 2) != 0;
    end
    desc_valid = 1'b0; s_valid = 1'b1; m_ready = 1'b1; cfg_ready = 1'b1;
    drain(1000);
    rec_en = 1'b0; mon_en = 1'b0; src_auto = 1'b0;

    // reset mid-STREAM after 2 of 6 words, with one more descriptor queued
    s_valid = 1'b1; s_data = 32'hBEEF0000; m_ready = 1'b0; cfg_ready = 1'b1;
    cyc(); desc_valid = 1'b1; desc_addr = 32'h4000; desc_len = 16'd6;
    cyc(); desc_addr = 32'h5000; desc_len = 16'd3;
    cyc(); desc_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!m_valid && n < 20) begin cyc(); @(negedge clk); n++; end
    chk("rst_stream_reached", 64'(m_valid), 64'd1);
    m_ready = 1'b1;
    @(posedge clk); @(posedge clk);
    watch = 1'b1;
    #3 arst_n = 1'b0;
    #1 check_reset("midrst");
    repeat (2) @(negedge clk);
    chk("midrst_level_held", 64'(level), 64'd0);
    arst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_no_done", 64'(saw_done), 64'd0);
    chk("midrst_busy_after", 64'(busy), 64'd0);
    chk("midrst_level_after", 64'(level), 64'd0);
    watch = 1'b0; m_ready = 1'b0; s_valid = 1'b0;

`ifdef IOB_AXIS2AXI_IN_SCHED_IRQ_EN
    // done and clear in the same cycle: set wins; clear alone afterwards drops it
    irq_clr = 1'b1;
    cyc(); desc_valid = 1'b1; desc_addr = 32'h6000; desc_len = 16'd0;
    cyc(); desc_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!done && n < 10) begin @(negedge clk); n++; end
    chk("irq_done_seen", 64'(done), 64'd1);
    @(negedge clk); chk("irq_set_wins", 64'(irq), 64'd1);
    @(negedge clk); chk("irq_cleared", 64'(irq), 64'd0);
    irq_clr = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end
endmodule
